// File: rtl/uart_spi_bridge_if.sv
// Pin and status bundle of uart_spi_bridge.
// master = bridge side; slave = pad/environment side.
interface uart_spi_bridge_if;
  logic [1:0] freq_control;
  logic       enable;
  logic       err_clr;
  logic       uart_rxd;
  logic       uart_txd;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic       busy;
  logic       rx_fifo_full;
  logic       tx_fifo_empty;
  logic       overrun;
  logic       frame_err;
  logic       parity_err;

  modport master (
    input  freq_control, enable, err_clr, uart_rxd, miso,
    output uart_txd, sclk, cs_n, mosi, busy,
           rx_fifo_full, tx_fifo_empty, overrun, frame_err, parity_err
  );

  modport slave (
    output freq_control, enable, err_clr, uart_rxd, miso,
    input  uart_txd, sclk, cs_n, mosi, busy,
           rx_fifo_full, tx_fifo_empty, overrun, frame_err, parity_err
  );
endinterface

// File: rtl/uart_spi_bridge.sv
// Full-duplex UART <-> SPI-master (mode 0) bridge with rx/tx byte FIFOs.
// Optional even-parity UART framing when UART_SPI_PARITY_EN is defined.
module uart_spi_bridge_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic          acc;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  // A push while full is still taken when a pop frees the slot this cycle.
  assign acc     = push_i && (!full_o || pop_i);
  assign dout_o  = mem_q[rp_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (acc)   wp_q <= wp_q + AW'(1);
      if (pop_i) rp_q <= rp_q + AW'(1);
      case ({acc, pop_i})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (acc) mem_q[wp_q] <= din_i;
  end
endmodule

module uart_spi_bridge #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int UART_DIV   = 16,
  parameter int SPI_DIV    = 4
) (
  input logic               clk,
  input logic               reset,
  uart_spi_bridge_if.master bus
);
  localparam int UCW = $clog2(UART_DIV + 1);
  localparam int SCW = $clog2(SPI_DIV + 1);
  localparam int BW  = $clog2(DATA_W);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd4;
`ifdef UART_SPI_PARITY_EN
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_AFTER = ST_PAR;
`else
  localparam logic [2:0] ST_AFTER = ST_STOP;
`endif

  localparam logic [2:0] SP_IDLE  = 3'd0;
  localparam logic [2:0] SP_SETUP = 3'd1;
  localparam logic [2:0] SP_HIGH  = 3'd2;
  localparam logic [2:0] SP_LOW   = 3'd3;
  localparam logic [2:0] SP_GUARD = 3'd4;

  // Rate select, latched by each engine at frame/transfer start.
  logic [31:0]    udiv_raw, sdiv_raw;
  logic [UCW-1:0] udiv_sel;
  logic [SCW-1:0] sdiv_sel;

  always_comb begin
    udiv_raw = UART_DIV >> bus.freq_control;
    sdiv_raw = SPI_DIV >> bus.freq_control;
    udiv_sel = (udiv_raw < 32'd8) ? UCW'(8) : UCW'(udiv_raw);
    sdiv_sel = (sdiv_raw < 32'd1) ? SCW'(1) : SCW'(sdiv_raw);
  end

  logic [DATA_W-1:0] rxf_dout, txf_dout;
  logic              rxf_empty, rxf_full, txf_empty, txf_full;
  logic              rx_push, tx_pop, spi_start, sp_push;

  // ---------------- UART receiver ----------------
  logic              rxs1_q, rxs2_q, rxp_q;
  logic [2:0]        rxst_q;
  logic [UCW-1:0]    rxcnt_q, rxdiv_q;
  logic [BW-1:0]     rxbit_q;
  logic [DATA_W-1:0] rxsh_q;
  logic              rx_tick, rx_half, rx_stop_smp, rx_ferr, rx_par_ok;

  assign rx_tick     = (rxcnt_q == rxdiv_q - UCW'(1));
  assign rx_half     = (rxcnt_q == (rxdiv_q >> 1) - UCW'(1));
  assign rx_stop_smp = (rxst_q == ST_STOP) && rx_tick;
  assign rx_ferr     = rx_stop_smp && !rxs2_q;
  assign rx_push     = rx_stop_smp && rxs2_q && rx_par_ok;

`ifdef UART_SPI_PARITY_EN
  logic rxpar_bad_q, rx_perr;
  assign rx_perr   = (rxst_q == ST_PAR) && rx_tick && (rxs2_q != ^rxsh_q);
  assign rx_par_ok = !rxpar_bad_q;
`else
  assign rx_par_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxs1_q  <= 1'b1;
      rxs2_q  <= 1'b1;
      rxp_q   <= 1'b1;
      rxst_q  <= ST_IDLE;
      rxcnt_q <= '0;
      rxdiv_q <= UCW'(8);
      rxbit_q <= '0;
      rxsh_q  <= '0;
`ifdef UART_SPI_PARITY_EN
      rxpar_bad_q <= 1'b0;
`endif
    end else begin
      rxs1_q <= bus.uart_rxd;
      rxs2_q <= rxs1_q;
      rxp_q  <= rxs2_q;
      case (rxst_q)
        ST_IDLE: if (rxp_q && !rxs2_q) begin
          rxst_q  <= ST_START;
          rxcnt_q <= '0;
          rxdiv_q <= udiv_sel;
`ifdef UART_SPI_PARITY_EN
          rxpar_bad_q <= 1'b0;
`endif
        end
        // Start bit must still be low at half-bit, otherwise it was a glitch.
        ST_START: if (rx_half) begin
          rxcnt_q <= '0;
          rxbit_q <= '0;
          rxst_q  <= rxs2_q ? ST_IDLE : ST_DATA;
        end else rxcnt_q <= rxcnt_q + UCW'(1);
        ST_DATA: if (rx_tick) begin
          rxcnt_q <= '0;
          rxsh_q  <= {rxs2_q, rxsh_q[DATA_W-1:1]};
          rxbit_q <= rxbit_q + BW'(1);
          if (rxbit_q == BW'(DATA_W - 1)) rxst_q <= ST_AFTER;
        end else rxcnt_q <= rxcnt_q + UCW'(1);
`ifdef UART_SPI_PARITY_EN
        ST_PAR: if (rx_tick) begin
          rxcnt_q     <= '0;
          rxpar_bad_q <= rx_perr;
          rxst_q      <= ST_STOP;
        end else rxcnt_q <= rxcnt_q + UCW'(1);
`endif
        ST_STOP: if (rx_tick) begin
          rxcnt_q <= '0;
          rxst_q  <= ST_IDLE;
        end else rxcnt_q <= rxcnt_q + UCW'(1);
        default: rxst_q <= ST_IDLE;
      endcase
    end
  end

  // ---------------- UART transmitter ----------------
  logic [2:0]        txst_q;
  logic [UCW-1:0]    txcnt_q, txdiv_q;
  logic [BW-1:0]     txbit_q;
  logic [DATA_W-1:0] txsh_q;
  logic              txd_q, tx_tick;

  assign tx_tick = (txcnt_q == txdiv_q - UCW'(1));
  assign tx_pop  = (txst_q == ST_IDLE) && !txf_empty;

`ifdef UART_SPI_PARITY_EN
  logic txpar_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txst_q  <= ST_IDLE;
      txcnt_q <= '0;
      txdiv_q <= UCW'(8);
      txbit_q <= '0;
      txsh_q  <= '0;
      txd_q   <= 1'b1;
`ifdef UART_SPI_PARITY_EN
      txpar_q <= 1'b0;
`endif
    end else begin
      case (txst_q)
        ST_IDLE: if (tx_pop) begin
          txsh_q  <= txf_dout;
          txd_q   <= 1'b0;
          txcnt_q <= '0;
          txdiv_q <= udiv_sel;
          txst_q  <= ST_START;
`ifdef UART_SPI_PARITY_EN
          txpar_q <= ^txf_dout;
`endif
        end
        ST_START: if (tx_tick) begin
          txcnt_q <= '0;
          txd_q   <= txsh_q[0];
          txsh_q  <= txsh_q >> 1;
          txbit_q <= '0;
          txst_q  <= ST_DATA;
        end else txcnt_q <= txcnt_q + UCW'(1);
        ST_DATA: if (tx_tick) begin
          txcnt_q <= '0;
          if (txbit_q == BW'(DATA_W - 1)) begin
            txst_q <= ST_AFTER;
`ifdef UART_SPI_PARITY_EN
            txd_q  <= txpar_q;
`else
            txd_q  <= 1'b1;
`endif
          end else begin
            txd_q   <= txsh_q[0];
            txsh_q  <= txsh_q >> 1;
            txbit_q <= txbit_q + BW'(1);
          end
        end else txcnt_q <= txcnt_q + UCW'(1);
`ifdef UART_SPI_PARITY_EN
        ST_PAR: if (tx_tick) begin
          txcnt_q <= '0;
          txd_q   <= 1'b1;
          txst_q  <= ST_STOP;
        end else txcnt_q <= txcnt_q + UCW'(1);
`endif
        ST_STOP: if (tx_tick) begin
          txcnt_q <= '0;
          txst_q  <= ST_IDLE;
        end else txcnt_q <= txcnt_q + UCW'(1);
        default: begin
          txst_q <= ST_IDLE;
          txd_q  <= 1'b1;
        end
      endcase
    end
  end

  // ---------------- SPI master ----------------
  logic [2:0]        spst_q;
  logic [SCW-1:0]    spcnt_q, spdiv_q;
  logic [BW-1:0]     spbit_q;
  logic [DATA_W-1:0] spsh_q, sprx_q;
  logic              sclk_q, cs_n_q, mosi_q, busy_q, sp_tick;

  assign sp_tick   = (spcnt_q == spdiv_q - SCW'(1));
  // tx_fifo space is reserved up front so a captured byte is never dropped.
  assign spi_start = (spst_q == SP_IDLE) && bus.enable && !rxf_empty && !txf_full;
  assign sp_push   = (spst_q == SP_HIGH) && sp_tick && (spbit_q == BW'(DATA_W - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      spst_q  <= SP_IDLE;
      spcnt_q <= '0;
      spdiv_q <= SCW'(1);
      spbit_q <= '0;
      spsh_q  <= '0;
      sprx_q  <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (spst_q)
        SP_IDLE: if (spi_start) begin
          spsh_q  <= rxf_dout;
          mosi_q  <= rxf_dout[DATA_W-1];
          cs_n_q  <= 1'b0;
          busy_q  <= 1'b1;
          spcnt_q <= '0;
          spdiv_q <= sdiv_sel;
          spst_q  <= SP_SETUP;
        end
        SP_SETUP: if (sp_tick) begin
          spcnt_q <= '0;
          sclk_q  <= 1'b1;
          sprx_q  <= {sprx_q[DATA_W-2:0], bus.miso};
          spbit_q <= '0;
          spst_q  <= SP_HIGH;
        end else spcnt_q <= spcnt_q + SCW'(1);
        SP_HIGH: if (sp_tick) begin
          spcnt_q <= '0;
          sclk_q  <= 1'b0;
          if (spbit_q == BW'(DATA_W - 1)) begin
            cs_n_q <= 1'b1;
            mosi_q <= 1'b0;
            spst_q <= SP_GUARD;
          end else begin
            mosi_q  <= spsh_q[DATA_W-2];
            spsh_q  <= spsh_q << 1;
            spbit_q <= spbit_q + BW'(1);
            spst_q  <= SP_LOW;
          end
        end else spcnt_q <= spcnt_q + SCW'(1);
        SP_LOW: if (sp_tick) begin
          spcnt_q <= '0;
          sclk_q  <= 1'b1;
          sprx_q  <= {sprx_q[DATA_W-2:0], bus.miso};
          spst_q  <= SP_HIGH;
        end else spcnt_q <= spcnt_q + SCW'(1);
        SP_GUARD: if (sp_tick) begin
          spcnt_q <= '0;
          busy_q  <= 1'b0;
          spst_q  <= SP_IDLE;
        end else spcnt_q <= spcnt_q + SCW'(1);
        default: begin
          spst_q <= SP_IDLE;
          cs_n_q <= 1'b1;
          sclk_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- FIFOs ----------------
  uart_spi_bridge_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(reset), .push_i(rx_push), .din_i(rxsh_q), .pop_i(spi_start),
    .dout_o(rxf_dout), .empty_o(rxf_empty), .full_o(rxf_full)
  );

  uart_spi_bridge_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(reset), .push_i(sp_push), .din_i(sprx_q), .pop_i(tx_pop),
    .dout_o(txf_dout), .empty_o(txf_empty), .full_o(txf_full)
  );

  // ---------------- Sticky flags (set beats clear) ----------------
  logic overrun_q, frame_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (rx_push && rxf_full && !spi_start) overrun_q <= 1'b1;
      else if (bus.err_clr)                  overrun_q <= 1'b0;
      if (rx_ferr)          frame_err_q <= 1'b1;
      else if (bus.err_clr) frame_err_q <= 1'b0;
    end
  end

`ifdef UART_SPI_PARITY_EN
  logic parity_err_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           parity_err_q <= 1'b0;
    else if (rx_perr)     parity_err_q <= 1'b1;
    else if (bus.err_clr) parity_err_q <= 1'b0;
  end
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.uart_txd      = txd_q;
  assign bus.sclk          = sclk_q;
  assign bus.cs_n          = cs_n_q;
  assign bus.mosi          = mosi_q;
  assign bus.busy          = busy_q;
  assign bus.rx_fifo_full  = rxf_full;
  assign bus.tx_fifo_empty = txf_empty;
  assign bus.overrun       = overrun_q;
  assign bus.frame_err     = frame_err_q;
endmodule
